dbc_bus_arbiter: RTL
====================

# dbc_bus_arbiter

Two-master arbiter and sequencer in front of the single port of `DataBusControl`. Master 0 is the core load/store unit and master 1 is the secondary requester (debug/DMA). Each master issues one transaction per request. The block performs round-robin arbitration, latches the winning request, drives the `DataBusControl` strobes for the exact number of cycles the registered RAM read path needs, and returns a one-cycle acknowledge with read data.

## Interface
- `READ_LAT`, default 1: extra cycles `dbc_rd` is held after the address cycle, for the registered RAM output.
- `TIMEOUT_CYCLES`, default 15: stall limit. Used only when `DBC_ARB_TIMEOUT_EN` is defined.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `m0_req`, `m1_req` in 1: transaction request. Held until `mX_gnt`.
- `m0_we`, `m1_we` in 1: 1 = write, 0 = read.
- `m0_size`, `m1_size` in 2: 0 = byte, 1 = half, 2 = word.
- `m0_addr`, `m1_addr` in 32: byte address.
- `m0_wdata`, `m1_wdata` in 32: write data.
- `m0_gnt`, `m1_gnt` out 1: one-cycle pulse. The request is latched; the master may change its inputs afterwards.
- `m0_ack`, `m1_ack` out 1: one-cycle completion pulse.
- `m0_rdata`, `m1_rdata` out 32: read data. Valid while `mX_ack` is high on a read; 0 otherwise.
- `m0_err`, `m1_err` out 1: timeout abort pulse, coincident with `mX_ack`.
- `dbc_wd`, `dbc_rd` out 1: `DataBusControl` write and read strobes.
- `dbc_size_in`, `dbc_size_out` out 2: latched size.
- `dbc_addr_in`, `dbc_addr_out` out 32: latched address. Driven on both ports.
- `dbc_data_in` out 32: latched write data.
- `dbc_data_out` in 32: read data from `DataBusControl`.
- `dbc_busy` in 1: `DataBusControl` busy.

## Operation
- States: IDLE, WRITE, READ.
- IDLE behaviour:
  - If any `mX_req` is high and `dbc_busy` is low, the rising edge selects a winner.
  - The winner's `we`/`size`/`addr`/`wdata` and its index `sel` are latched.
  - The next state is WRITE (`we` = 1) or READ (`we` = 0).
  - `mX_gnt` of the winner is high for the first cycle of that state.
- Arbitration:
  - Only one master requesting: that master wins.
  - Both requesting: the master not equal to `last` wins.
  - `last` updates to `sel` on every grant. Reset value of `last` is 1, so master 0 wins the first tie.
- WRITE state:
  - `dbc_wd` = 1 with the latched fields.
  - At an edge with `dbc_busy` low: go to IDLE and register `ack[sel]` = 1 for the next cycle.
- READ state:
  - `dbc_rd` = 1 with the latched fields.
  - A counter `cnt` (width clog2(READ_LAT+1), cleared on entry) increments on each edge where `dbc_busy` is low.
  - At the edge where `cnt` == READ_LAT and `dbc_busy` is low: capture `dbc_data_out` into the rdata register for `sel`, go to IDLE, and register `ack[sel]` = 1.
- `dbc_busy` high in WRITE or READ: stall. Strobes, fields and `cnt` are held.
- In IDLE, `dbc_wd` = `dbc_rd` = 0 and the `dbc_*` fields hold their last latched values.
- Reset:
  - All outputs are 0.
  - State = IDLE, `cnt` = 0, latched fields = 0, `last` = 1.
  - Reset mid-transaction aborts it with no `ack` or `err`.
- Requests arriving while the arbiter is busy are not lost; they are held by the master and arbitrated in the next IDLE.

## Timing
- Write, E0 = edge that samples `req` in IDLE:
  - cycle 1: `gnt` + `dbc_wd`.
  - cycle 2: `ack`.
  - Latency is 2 cycles when not stalled.
- Read with READ_LAT = 1:
  - cycle 1: `gnt` + `dbc_rd`.
  - cycle 2: `dbc_rd`, data valid from `DataBusControl`.
  - cycle 3: `ack` with `rdata`.
  - Latency is READ_LAT + 2 cycles.
- The IDLE cycle coinciding with `ack` may sample a new request. Back-to-back throughput is one write per 2 cycles and one read per READ_LAT + 2 cycles.
- Each `dbc_busy`-high cycle adds exactly one cycle of latency.

## Configuration
- `DBC_ARB_TIMEOUT_EN` defined:
  - A stall counter runs during WRITE and READ, counting consecutive `dbc_busy`-high cycles.
  - When the counter reaches TIMEOUT_CYCLES, the transaction is aborted: go to IDLE and next cycle pulse `ack[sel]` = `err[sel]` = 1 with `rdata` = 0.
  - The counter clears on entering WRITE or READ and on any `dbc_busy`-low cycle.
- `DBC_ARB_TIMEOUT_EN` undefined:
  - No stall counter; a stall is unbounded.
  - `m0_err` and `m1_err` are tied to 0.

## Test plan
- Reset, then m0 write of 0xDEADBEEF, size 2, to 0x100 → `m0_gnt` in cycle 1 with `dbc_wd` = 1, `dbc_addr_in` = 0x100, `dbc_data_in` = 0xDEADBEEF; `m0_ack` in cycle 2.
- m1 read of 0x100 after that write, with `dbc_data_out` modelled as a registered RAM → `dbc_rd` high for 2 cycles; `m1_ack` in cycle 3 with `m1_rdata` = 0xDEADBEEF; `m0_rdata` = 0.
- m0 and m1 both hold `req` continuously for 4 transactions → grants alternate m0, m1, m0, m1; no cycle has both `gnt` high.
- `dbc_busy` forced high for 3 cycles during a READ → strobes and address held; `ack` arrives 3 cycles late with correct data.
- `rst` asserted asynchronously mid-READ → outputs 0 immediately; no `ack`; the first grant after release goes to m0 on a tie.
- With `DBC_ARB_TIMEOUT_EN` defined and `dbc_busy` stuck high → after 15 stall cycles, `m0_ack` = `m0_err` = 1, `m0_rdata` = 0, and the next request is granted.

Source files
------------

// File: rtl/dbc_bus_arbiter.sv
// Two-master round-robin arbiter and strobe sequencer for the DataBusControl port.
// Optional stall timeout is compiled in with `define DBC_ARB_TIMEOUT_EN.
module dbc_bus_arbiter #(
  parameter int READ_LAT       = 1,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [1:0]  m0_size,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [1:0]  m1_size,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_ack,
  output logic        m1_ack,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        m0_err,
  output logic        m1_err,
  output logic        dbc_wd,
  output logic        dbc_rd,
  output logic [1:0]  dbc_size_in,
  output logic [1:0]  dbc_size_out,
  output logic [31:0] dbc_addr_in,
  output logic [31:0] dbc_addr_out,
  output logic [31:0] dbc_data_in,
  input  logic [31:0] dbc_data_out,
  input  logic        dbc_busy
);

  localparam int CNT_W = (READ_LAT > 0) ? $clog2(READ_LAT + 1) : 1;

  if (READ_LAT < 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("dbc_bus_arbiter: READ_LAT must be >= 0 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t             state;
  logic               sel;
  logic               last;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         size;
  logic [31:0]        addr;
  logic [31:0]        wdata;
  logic               win;
  logic               start;
  logic               abort;

  // Tie goes to the master that did not win last time.
  assign win   = (m0_req & m1_req) ? ~last : m1_req;
  assign start = (state == IDLE) & (m0_req | m1_req) & ~dbc_busy;

  assign dbc_wd       = (state == WRITE);
  assign dbc_rd       = (state == READ);
  assign dbc_size_in  = size;
  assign dbc_size_out = size;
  assign dbc_addr_in  = addr;
  assign dbc_addr_out = addr;
  assign dbc_data_in  = wdata;

`ifdef DBC_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [STALL_W-1:0] stall_cnt;

  assign abort = (state != IDLE) & dbc_busy &
                 (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1));

  // Counts consecutive busy cycles; parked at zero in IDLE so entry starts clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      m0_err    <= 1'b0;
      m1_err    <= 1'b0;
    end else begin
      m0_err <= abort & ~sel;
      m1_err <= abort & sel;
      if (state == IDLE || !dbc_busy || abort) begin
        stall_cnt <= '0;
      end else begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end
`else
  assign abort  = 1'b0;
  assign m0_err = 1'b0;
  assign m1_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= 1'b0;
      last     <= 1'b1;
      cnt      <= '0;
      size     <= '0;
      addr     <= '0;
      wdata    <= '0;
      m0_gnt   <= 1'b0;
      m1_gnt   <= 1'b0;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      m0_gnt   <= 1'b0;
      m1_gnt   <= 1'b0;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
      if (abort) begin
        state  <= IDLE;
        m0_ack <= ~sel;
        m1_ack <= sel;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              sel    <= win;
              last   <= win;
              cnt    <= '0;
              size   <= win ? m1_size  : m0_size;
              addr   <= win ? m1_addr  : m0_addr;
              wdata  <= win ? m1_wdata : m0_wdata;
              state  <= (win ? m1_we : m0_we) ? WRITE : READ;
              m0_gnt <= ~win;
              m1_gnt <= win;
            end
          end
          WRITE: begin
            if (!dbc_busy) begin
              state  <= IDLE;
              m0_ack <= ~sel;
              m1_ack <= sel;
            end
          end
          READ: begin
            // Strobe stays up until the registered RAM output has caught up.
            if (!dbc_busy) begin
              if (cnt == CNT_W'(READ_LAT)) begin
                state  <= IDLE;
                m0_ack <= ~sel;
                m1_ack <= sel;
                if (sel) m1_rdata <= dbc_data_out;
                else     m0_rdata <= dbc_data_out;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
